// File: rtl/csr_pkg.sv
// Shared CSR address map, mstatus field positions and the misa constant.
// Imported by the CSR file top; holds no logic beyond the read-only test.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  localparam logic [31:0] MISA_VAL = 32'h4000_0100;

  // Address bits [11:10] == 2'b11 encode a read-only CSR.
  function automatic logic is_readonly(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/reg_csr_file_if.sv
// CSR access port between the pipeline (master) and the CSR file (slave).
// Read side is decode-captured; write side is the commit-stage write.
interface reg_csr_file_if;
  logic [11:0] RIADDR;
  logic        RVALID;
  logic [11:0] ROADDR;
  logic [31:0] RDATA;
  logic        RILLEGAL;
  logic        WREN;
  logic [11:0] WADDR;
  logic [31:0] WDATA;

  modport master (
    output RIADDR, WREN, WADDR, WDATA,
    input  RVALID, ROADDR, RDATA, RILLEGAL
  );

  modport slave (
    input  RIADDR, WREN, WADDR, WDATA,
    output RVALID, ROADDR, RDATA, RILLEGAL
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable halves.
// A write to either half replaces it and suppresses that cycle's increment.
module csr_counter64 (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INC,
  input  logic        WR_LO,
  input  logic        WR_HI,
  input  logic [31:0] WDATA,
  output logic [63:0] COUNT
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      COUNT <= '0;
    end else if (WR_LO || WR_HI) begin
      if (WR_LO) COUNT[31:0]  <= WDATA;
      if (WR_HI) COUNT[63:32] <= WDATA;
    end else begin
      COUNT <= COUNT + {63'b0, INC};
    end
  end

endmodule

// File: rtl/reg_csr_file.sv
// Machine-mode CSR file: captured read with forwarding/hazard resolution, trap entry/MRET, counters.
// Read data is combinational from state captured one edge earlier; RVALID=0 asks the pipeline to stall.
module reg_csr_file
  import csr_pkg::*;
#(
  parameter int          FWD_STAGES  = 2,
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RST   = 32'h0,
  parameter bit          COUNTERS_EN = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     FLUSH,
  input  logic                     STALL,
  input  logic                     MEM_WAIT,
  reg_csr_file_if.slave            bus,
  input  logic [11:0]              FWD_CSR_ADDR,
  input  logic [FWD_STAGES-1:0]    FWD_EN,
  input  logic [12*FWD_STAGES-1:0] FWD_ADDR,
  input  logic [32*FWD_STAGES-1:0] FWD_DATA,
  input  logic                     RETIRE,
  input  logic                     TRAP_EN,
  input  logic [31:0]              TRAP_PC,
  input  logic [31:0]              TRAP_CAUSE,
  input  logic [31:0]              TRAP_TVAL,
  input  logic                     MRET,
  output logic [31:0]              TRAP_VEC,
  output logic [31:0]              EPC,
  output logic                     MIE
);

  logic [11:0]              riaddr_q;
  logic                     wren_q;
  logic [11:0]              waddr_q;
  logic [31:0]              wdata_q;
  logic [11:0]              fwd_csr_addr_q;
  logic [FWD_STAGES-1:0]    fwd_en_q;
  logic [12*FWD_STAGES-1:0] fwd_addr_q;
  logic [32*FWD_STAGES-1:0] fwd_data_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST || FLUSH) begin
      riaddr_q       <= '0;
      wren_q         <= 1'b0;
      waddr_q        <= '0;
      wdata_q        <= '0;
      fwd_csr_addr_q <= '0;
      fwd_en_q       <= '0;
      fwd_addr_q     <= '0;
      fwd_data_q     <= '0;
    end else if (STALL) begin
      // The stalled read waits for its producer, so the hazard tag is dropped.
      fwd_csr_addr_q <= '0;
      fwd_en_q       <= FWD_EN;
      fwd_addr_q     <= FWD_ADDR;
      fwd_data_q     <= FWD_DATA;
    end else if (!MEM_WAIT) begin
      riaddr_q       <= bus.RIADDR;
      wren_q         <= bus.WREN;
      waddr_q        <= bus.WADDR;
      wdata_q        <= bus.WDATA;
      fwd_csr_addr_q <= FWD_CSR_ADDR;
      fwd_en_q       <= FWD_EN;
      fwd_addr_q     <= FWD_ADDR;
      fwd_data_q     <= FWD_DATA;
    end
  end

  logic        csr_we;
  logic        mie_q;
  logic        mpie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;

  assign csr_we = bus.WREN && !is_readonly(bus.WADDR);

  // Later statements override earlier ones: TRAP_EN beats MRET beats the CSR write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST & ~32'h3;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      if (csr_we) begin
        case (bus.WADDR)
          CSR_MSTATUS: begin
            mie_q  <= bus.WDATA[MSTATUS_MIE];
            mpie_q <= bus.WDATA[MSTATUS_MPIE];
          end
          CSR_MTVEC:    mtvec_q    <= bus.WDATA & ~32'h3;
          CSR_MSCRATCH: mscratch_q <= bus.WDATA;
          CSR_MEPC:     mepc_q     <= bus.WDATA & ~32'h3;
          CSR_MCAUSE:   mcause_q   <= bus.WDATA;
          CSR_MTVAL:    mtval_q    <= bus.WDATA;
          default: ;
        endcase
      end
      if (MRET) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end
      if (TRAP_EN) begin
        mepc_q   <= TRAP_PC & ~32'h3;
        mcause_q <= TRAP_CAUSE;
        mtval_q  <= TRAP_TVAL;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end
    end
  end

  logic [63:0] mcycle;
  logic [63:0] minstret;

  if (COUNTERS_EN) begin : g_counters
    csr_counter64 u_mcycle (
      .CLK   (CLK),
      .RST   (RST),
      .INC   (1'b1),
      .WR_LO (csr_we && (bus.WADDR == CSR_MCYCLE)),
      .WR_HI (csr_we && (bus.WADDR == CSR_MCYCLEH)),
      .WDATA (bus.WDATA),
      .COUNT (mcycle)
    );
    csr_counter64 u_minstret (
      .CLK   (CLK),
      .RST   (RST),
      .INC   (RETIRE),
      .WR_LO (csr_we && (bus.WADDR == CSR_MINSTRET)),
      .WR_HI (csr_we && (bus.WADDR == CSR_MINSTRETH)),
      .WDATA (bus.WDATA),
      .COUNT (minstret)
    );
  end else begin : g_no_counters
    assign mcycle   = '0;
    assign minstret = '0;
  end

  logic [31:0] mstatus_val;
  logic [31:0] csr_rdata;
  logic        csr_impl;

  always_comb begin
    mstatus_val                       = '0;
    mstatus_val[MSTATUS_MIE]          = mie_q;
    mstatus_val[MSTATUS_MPIE]         = mpie_q;
    mstatus_val[MSTATUS_MPP_LO +: 2]  = 2'b11;
  end

  always_comb begin
    csr_rdata = '0;
    csr_impl  = 1'b1;
    case (riaddr_q)
      CSR_MSTATUS:                 csr_rdata = mstatus_val;
      CSR_MISA:                    csr_rdata = MISA_VAL;
      CSR_MTVEC:                   csr_rdata = mtvec_q;
      CSR_MSCRATCH:                csr_rdata = mscratch_q;
      CSR_MEPC:                    csr_rdata = mepc_q;
      CSR_MCAUSE:                  csr_rdata = mcause_q;
      CSR_MTVAL:                   csr_rdata = mtval_q;
      CSR_MVENDORID, CSR_MARCHID,
      CSR_MIMPID:                  csr_rdata = '0;
      CSR_MHARTID:                 csr_rdata = HART_ID;
      CSR_MCYCLE, CSR_CYCLE: begin
        csr_rdata = mcycle[31:0];
        csr_impl  = COUNTERS_EN;
      end
      CSR_MCYCLEH, CSR_CYCLEH: begin
        csr_rdata = mcycle[63:32];
        csr_impl  = COUNTERS_EN;
      end
      CSR_MINSTRET, CSR_INSTRET: begin
        csr_rdata = minstret[31:0];
        csr_impl  = COUNTERS_EN;
      end
      CSR_MINSTRETH, CSR_INSTRETH: begin
        csr_rdata = minstret[63:32];
        csr_impl  = COUNTERS_EN;
      end
      default:                     csr_impl  = 1'b0;
    endcase
  end

  // Chain built from the oldest source down so index 0 (youngest) wins.
  logic [31:0] chain_dat [0:FWD_STAGES];
  logic        chain_vld [0:FWD_STAGES];

  assign chain_dat[FWD_STAGES] = (wren_q && (waddr_q == riaddr_q)) ? wdata_q : csr_rdata;
  assign chain_vld[FWD_STAGES] = 1'b1;

  for (genvar i = FWD_STAGES - 1; i >= 0; i--) begin : g_fwd
    logic hit;
    assign hit          = (fwd_addr_q[12*i +: 12] == riaddr_q);
    assign chain_dat[i] = hit ? fwd_data_q[32*i +: 32] : chain_dat[i+1];
    assign chain_vld[i] = hit ? fwd_en_q[i]            : chain_vld[i+1];
  end

  always_comb begin
    bus.RVALID = chain_vld[0];
    bus.RDATA  = chain_dat[0];
    if (riaddr_q == '0) begin
      bus.RVALID = 1'b1;
      bus.RDATA  = '0;
    end else if (riaddr_q == fwd_csr_addr_q) begin
      bus.RVALID = 1'b0;
    end
  end

  assign bus.ROADDR   = riaddr_q;
  assign bus.RILLEGAL = ((riaddr_q != '0) && !csr_impl) || (wren_q && is_readonly(waddr_q));

  assign TRAP_VEC = mtvec_q;
  assign EPC      = mepc_q;
  assign MIE      = mie_q;

endmodule
